// File: rtl/gecko_decrypt.sv
// Byte-stream decryptor: loads the gecko key, then XORs each ciphertext byte with one keystream byte.
// Optional one-byte keystream prefetch buffer is enabled by defining GECKO_DECRYPT_PREFETCH_EN.
module gecko_decrypt #(
  parameter int KEY_LENGTH = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] key_sel,
  output logic       ks_clken,
  input  logic       ks_ready,
  input  logic [7:0] ks_byte,
  output logic       ks_next,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [0:0] {
    KEYLOAD = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] lc_r, lc_s;
  logic [2:0] key_sel_r, key_sel_s;
  logic       out_valid_r, out_valid_s;
  logic [7:0] out_data_r, out_data_s;
  logic       run_s;
  logic       ks_avail_s;
  logic [7:0] kbyte_s;
  logic       xfer_s;

  assign run_s    = (state_r == RUN);
  assign in_ready = run_s & ks_avail_s & (~out_valid_r | out_ready);
  assign xfer_s   = in_valid & in_ready;
  assign ks_clken = 1'b1;
  assign key_sel  = key_sel_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = ~run_s | out_valid_r;

`ifdef GECKO_DECRYPT_PREFETCH_EN
  logic       kv_r;
  logic [7:0] kbuf_r;
  logic       refill_s;

  // Refill may coincide with a consume, keeping the buffer full while the generator keeps up.
  assign refill_s   = run_s & ks_ready & (~kv_r | xfer_s);
  assign ks_avail_s = kv_r;
  assign kbyte_s    = kbuf_r;
  assign ks_next    = refill_s;

  // Keystream buffer: capture on refill, release on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_r   <= 1'b0;
      kbuf_r <= 8'h00;
    end else if (refill_s) begin
      kv_r   <= 1'b1;
      kbuf_r <= ks_byte;
    end else if (xfer_s) begin
      kv_r   <= 1'b0;
    end else begin
      kv_r   <= kv_r;
    end
  end
`else
  assign ks_avail_s = ks_ready;
  assign kbyte_s    = ks_byte;
  assign ks_next    = xfer_s;
`endif

  // Next state and load counter; lc holds at 15 once RUN is reached.
  always_comb begin
    state_s = state_r;
    lc_s    = lc_r;
    case (state_r)
      KEYLOAD: begin
        if (lc_r == 4'd15) begin
          state_s = RUN;
          lc_s    = lc_r;
        end else begin
          state_s = KEYLOAD;
          lc_s    = lc_r + 4'd1;
        end
      end
      RUN: begin
        state_s = RUN;
        lc_s    = lc_r;
      end
      default: begin
        state_s = KEYLOAD;
        lc_s    = 4'd0;
      end
    endcase
  end

  // key_sel is computed from the next count so the register lines up with gecko's sampling edge.
  always_comb begin
    key_sel_s = 3'd0;
    if ((state_s == KEYLOAD) && (lc_s < 4'(KEY_LENGTH))) begin
      key_sel_s = lc_s[2:0];
    end else begin
      key_sel_s = 3'd0;
    end
  end

  // Output register: load on transfer, otherwise drain on downstream accept.
  always_comb begin
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    if (xfer_s) begin
      out_valid_s = 1'b1;
      out_data_s  = in_data ^ kbyte_s;
    end else if (out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= KEYLOAD;
      lc_r        <= 4'd0;
      key_sel_r   <= 3'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      state_r     <= state_s;
      lc_r        <= lc_s;
      key_sel_r   <= key_sel_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
    end
  end

endmodule

// File: doc/gecko_decrypt.md
# gecko_decrypt

Byte-stream decryptor that consumes the gecko keystream generator. It drives the generator's key-byte index during key load and issues `next` requests. Each accepted ciphertext byte is XORed with one keystream byte and presented on a valid/ready output port. It sits between the boot/flash byte reader and the code loader. With an all-zero key, gecko's keystream is constant 0x00 and this block passes data through at one byte per cycle.

## Interface
- KEY_LENGTH, 7: key bytes presented during load. Must match gecko's KEY_LENGTH.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low. Shared with gecko.
- key_sel  out  3  index of key byte the key store must drive onto gecko `key`
- ks_clken  out  1  gecko clock enable
- ks_ready  in  1  gecko `ready`: ks_byte holds an unconsumed keystream byte
- ks_byte  in  8  gecko `dout`
- ks_next  out  1  gecko `next`; one-cycle pulse consumes ks_byte
- in_valid  in  1  ciphertext byte valid
- in_ready  out  1  ciphertext byte accepted this cycle when in_valid is also high
- in_data  in  8  ciphertext byte
- out_valid  out  1  plaintext byte valid
- out_ready  in  1  downstream accepts plaintext
- out_data  out  8  plaintext byte
- busy  out  1  high in KEYLOAD or while an output byte is pending

## Operation
- States: KEYLOAD, RUN.
- Reset value of the state register: KEYLOAD.
- KEYLOAD:
  - A 4-bit load counter lc counts 0..15. ks_clken is 1.
  - key_sel equals lc while lc < KEY_LENGTH; otherwise key_sel is 0.
  - At lc = 15 the block moves to RUN.
- RUN:
  - ks_clken stays 1.
  - key_sel is 0.
- Transfer rule:
  - xfer = RUN & in_valid & in_ready.
  - in_ready = RUN & ks_avail & (!out_valid | out_ready).
- Without prefetch: ks_avail = ks_ready and kbyte = ks_byte.
- On xfer:
  - out_data <= in_data ^ kbyte.
  - out_valid <= 1.
  - ks_next = 1 in the same cycle.
- Output handshake:
  - out_valid clears on out_ready when there is no simultaneous xfer.
  - On simultaneous accept and xfer, out_valid stays 1 and out_data updates.
- Zero-key boundary:
  - gecko holds ks_ready = 1 and ks_byte = 0x00 and ignores next.
  - The block therefore streams in_data straight through, one byte per cycle.
- ks_next is never asserted when ks_ready = 0 or outside RUN.
- Reset mid-stream: all state is discarded and load restarts at lc = 0. gecko restarts in lockstep because it shares rst_n. A partially delivered output byte is lost.
- Arithmetic: pure 8-bit XOR, no carries. lc saturates only via the state change.

## Timing
- Reset values:
  - key_sel 0, ks_clken 1, ks_next 0.
  - in_ready 0, out_valid 0, out_data 0x00, busy 1.
- key_sel is registered-aligned so that gecko samples key byte i on clock edge i+1 after reset release, for i = 0..KEY_LENGTH-1.
- KEYLOAD lasts exactly 16 cycles. in_ready = 0 throughout.
- Latency is 1 cycle, from xfer to out_valid.
- ks_next is combinational from xfer. gecko drops ks_ready on the following edge.
- Nonzero-key throughput without prefetch: one byte per 9 cycles at most (8 generator cycles plus the consume cycle).
- Zero-key throughput: one byte per cycle when out_ready = 1.

## Configuration
- GECKO_DECRYPT_PREFETCH_EN defined:
  - Adds a one-byte keystream buffer kbuf with a valid flag kv.
  - When RUN & !kv & ks_ready: kbuf <= ks_byte, kv <= 1, ks_next pulses.
  - ks_avail = kv and kbyte = kbuf. kv clears on xfer unless refilled in the same cycle.
  - Effect: the generator computes the next byte while the block waits for input, so a byte arriving ≥9 cycles after the previous one is accepted without stall.
  - Output timing: adds no latency.
- GECKO_DECRYPT_PREFETCH_EN undefined: no buffer; behaviour as in Operation.

## Test plan
- Reset release, key store returning 0x11·(i+1) -> key_sel = 0,1,…,6 on cycles 0–6, then 0; in_ready = 0 for cycles 0–15.
- All-zero key, in_data 0x00..0x0F back-to-back, out_ready = 1 -> out_data 0x00..0x0F, one per cycle, ks_next pulses on every transfer.
- Model gecko with ks_byte = 0x3C, in_data 0xA5 -> out_data 0x99 one cycle later; ks_next single-cycle pulse; in_ready = 0 until the model reasserts ks_ready.
- out_ready held 0 with out_valid = 1 for 20 cycles -> out_data stable, in_ready = 0, no ks_next; release -> next byte accepted the same cycle.
- Real gecko with key 0x5A...: decrypt a 32-byte buffer encrypted by key.c -> matches plaintext. Spacing is ≥9 cycles without the macro. With the macro, a byte arriving 12 cycles after the previous one sees in_ready = 1 on arrival.
- rst_n pulsed low during byte 5 -> out_valid 0 immediately, load restarts with key_sel from 0, and the stream restarts at keystream byte 0.
